// File: rtl/sram_pkg.sv
// Shared types for the SRAM controller: width defaults, FSM states and the queued command.
package sram_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CAPT,
        S_RSP
    } state_e;

    typedef struct packed {
        logic              rw;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/sram_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on dout_o whenever empty_o is low.
module sram_cmd_fifo
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cmd_t din_i,
    input  logic pop_i,
    output cmd_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Queued single-port SRAM controller: in-order writes and reads with a held read response.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rw,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    // The queued command layout is fixed by the package struct.
    if (AW != AW_DEF || DW != DW_DEF || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("sram_ctrl: AW/DW must match sram_pkg and DEPTH must be a power of 2 >= 2");
    end

    state_e        state_q, state_d;
    logic          mem_rw_q, mem_rw_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;

    cmd_t fifo_din, fifo_head;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_din  = '{rw: req_rw, addr: req_addr, wdata: req_wdata};
    assign fifo_push = req_valid && !fifo_full;

    sram_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // SRAM drive is registered at the pop edge so WRITE/READ see it for their whole cycle.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        mem_rw_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    mem_addr_d = fifo_head.addr;
                    if (fifo_head.rw) begin
                        mem_rw_d  = 1'b1;
                        mem_din_d = fifo_head.wdata;
                        state_d   = S_WRITE;
                    end else begin
                        state_d   = S_READ;
                    end
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ:  state_d = S_CAPT;
            S_CAPT: begin
                rsp_data_d  = mem_dout;
                rsp_addr_d  = mem_addr_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
        end
    end

    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != S_IDLE);
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM model, in-order reference memory and directed scenarios.
module tb_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_rw;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data, rsp_addr;
    logic       mem_rw;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic       busy;

    always #5 clk = ~clk;

    sram_ctrl #(.DEPTH(4), .AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .busy      (busy)
    );

    // Synchronous SRAM: write on mem_rw, read data registered every edge.
    logic [7:0] sram [256];
    always @(posedge clk) begin
        if (mem_rw) sram[mem_addr] <= mem_din;
        mem_dout <= sram[mem_addr];
    end

    // Reference: commands applied in acceptance order to a flat memory.
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;
    logic [7:0] ref_mem [256];
    ev_t        rq[$];
    ev_t        wq[$];
    logic [7:0] rsp_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rw) begin
                chk("write_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    chk("wr_addr", mem_addr, wq[0].a);
                    chk("wr_data", mem_din, wq[0].d);
                    void'(wq.pop_front());
                end
            end
            if (rsp_valid) begin
                chk("rsp_expected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    chk("rsp_addr", rsp_addr, rq[0].a);
                    chk("rsp_data", rsp_data, rq[0].d);
                    if (rsp_ready) begin
                        rsp_log.push_back(rsp_data);
                        void'(rq.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic rw, input logic [7:0] a, input logic [7:0] d);
        int   c;
        logic acc;
        c   = 0;
        acc = 1'b0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
        while (!acc && c < 50) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            c++;
        end
        #1 req_valid = 1'b0;
        chk("accept", acc, 1);
        if (acc) begin
            if (rw) begin
                ref_mem[a] = d;
                wq.push_back('{a: a, d: d});
            end else begin
                rq.push_back('{a: a, d: ref_mem[a]});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 100) begin
            step();
            c++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] exp_log [10];

    initial begin
        exp_log = '{8'hA5, 8'h3C, 8'hC3, 8'h11, 8'h22, 8'hA5, 8'h11, 8'h22, 8'hA5, 8'h11};
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_rw = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Write latency: commit cycle right after the pop edge.
        send(1'b1, 8'h10, 8'hA5);
        chk("w_busy_E0", busy, 1);
        step();
        chk("w_mem_rw_E1", mem_rw, 1);
        chk("w_mem_addr_E1", mem_addr, 8'h10);
        chk("w_mem_din_E1", mem_din, 8'hA5);
        step();
        chk("w_mem_rw_E2", mem_rw, 0);
        wait_idle();

        // Read latency: rsp_valid from the third edge after acceptance.
        send(1'b0, 8'h10, 8'h00);
        step();
        chk("r_valid_E1", rsp_valid, 0);
        chk("r_mem_rw_E1", mem_rw, 0);
        chk("r_mem_addr_E1", mem_addr, 8'h10);
        step();
        chk("r_valid_E2", rsp_valid, 0);
        step();
        chk("r_valid_E3", rsp_valid, 1);
        chk("r_data_E3", rsp_data, 8'hA5);
        chk("r_addr_E3", rsp_addr, 8'h10);
        wait_idle();

        // Ordering on one address.
        send(1'b1, 8'hFF, 8'h3C);
        send(1'b0, 8'hFF, 8'h00);
        send(1'b1, 8'hFF, 8'hC3);
        send(1'b0, 8'hFF, 8'h00);
        wait_idle();

        // Address extremes.
        send(1'b1, 8'h00, 8'h11);
        send(1'b1, 8'hFF, 8'h22);
        send(1'b0, 8'h00, 8'h00);
        send(1'b0, 8'hFF, 8'h00);
        wait_idle();

        // Full FIFO behind a stalled response, plus backpressure stability.
        rsp_ready = 1'b0;
        send(1'b0, 8'h10, 8'h00);
        begin
            int c;
            c = 0;
            while (!rsp_valid && c < 10) begin
                step();
                c++;
            end
        end
        chk("stall_rsp_valid", rsp_valid, 1);
        send(1'b0, 8'h00, 8'h00);
        send(1'b0, 8'hFF, 8'h00);
        send(1'b0, 8'h10, 8'h00);
        send(1'b0, 8'h00, 8'h00);
        chk("full_req_ready", req_ready, 0);
        chk("full_busy", busy, 1);
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 8'h33;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 8'hA5);
            chk("bp_mem_rw", mem_rw, 0);
        end
        req_valid = 1'b0;
        step();
        rsp_ready = 1'b1;
        wait_idle();
        chk("drain_rq_empty", rq.size(), 0);
        chk("rsp_count", rsp_log.size(), 10);
        for (int i = 0; i < 10 && i < rsp_log.size(); i++) begin
            chk("rsp_log", rsp_log[i], exp_log[i]);
        end

        // Reset in the middle of a read with a write still queued.
        send(1'b0, 8'h10, 8'h00);
        send(1'b1, 8'h77, 8'h99);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_rw", mem_rw, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        rq.delete();
        wq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_no_rsp", rsp_log.size(), 10);
        chk("wq_empty", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
